// File: rtl/sbox_feed_packer.sv
// Repacks an MSB-first byte stream into 6-bit S-box input symbols, zero-padding the last one.
// Optional length trailer (two 6-bit symbols of byte_count) enabled by SBOX_FEED_LEN_TRAILER_EN.
module sbox_feed_packer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_data,
  output logic             out_last,
  output logic [LEN_W-1:0] byte_count
);

`ifdef SBOX_FEED_LEN_TRAILER_EN
  typedef enum logic [1:0] {RUN, FLUSH, TRL_HI, TRL_LO} state_e;
`else
  typedef enum logic {RUN, FLUSH} state_e;
`endif

  state_e           state_q, state_d;
  logic [13:0]      bit_buf_q, bit_buf_d;
  logic [3:0]       fill_q, fill_d;
  logic [LEN_W-1:0] count_q, count_d;

  assign byte_count = count_q;

  always_comb begin
    state_d   = state_q;
    bit_buf_d = bit_buf_q;
    fill_d    = fill_q;
    count_d   = count_q;

    in_ready  = (state_q == RUN) && (fill_q <= 4'd5) && !rst;
    out_valid = (fill_q >= 4'd6) || ((state_q == FLUSH) && (fill_q != 4'd0));
    out_data  = bit_buf_q[13:8];
    out_last  = 1'b0;

`ifdef SBOX_FEED_LEN_TRAILER_EN
    if (state_q == TRL_HI) begin
      out_valid = 1'b1;
      out_data  = count_q[11:6];
    end else if (state_q == TRL_LO) begin
      out_valid = 1'b1;
      out_data  = count_q[5:0];
      out_last  = 1'b1;
    end
`else
    out_last = (state_q == FLUSH) && (fill_q <= 4'd6);
`endif

    // Bits below fill are always zero, so a byte can be OR-ed in right under them.
    if (in_valid && in_ready) begin
      bit_buf_d = bit_buf_q | ({in_data, 6'b000000} >> fill_q);
      fill_d    = fill_q + 4'd8;
      count_d   = count_q + LEN_W'(1);
      if (in_last) state_d = FLUSH;
    end

    if (out_valid && out_ready) begin
`ifdef SBOX_FEED_LEN_TRAILER_EN
      if (state_q == TRL_HI) begin
        state_d = TRL_LO;
      end else if (state_q == TRL_LO) begin
        state_d = RUN;
        count_d = '0;
      end else begin
        bit_buf_d = bit_buf_q << 6;
        fill_d    = (fill_q >= 4'd6) ? (fill_q - 4'd6) : 4'd0;
        if ((state_q == FLUSH) && (fill_d == 4'd0)) state_d = TRL_HI;
      end
`else
      bit_buf_d = bit_buf_q << 6;
      fill_d    = (fill_q >= 4'd6) ? (fill_q - 4'd6) : 4'd0;
      if (out_last) begin
        state_d = RUN;
        count_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      bit_buf_q <= '0;
      fill_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_buf_q <= bit_buf_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
    end
  end

endmodule
